// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings used by bus initiators and responders.
package ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

endpackage

// File: rtl/ahb_master_if.sv
// AHB-Lite initiator: one outstanding SINGLE transfer per core request,
// with wait-state counting and two-cycle ERROR response handling.
module ahb_master_if
  import ahb_pkg::*;
#(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter logic [2:0]  HSIZE_VAL = HSIZE_WORD,
  parameter int unsigned WAIT_W    = 8
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              req_ready,
  output logic              rsp_valid,
  output logic              rsp_err,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [WAIT_W-1:0] rsp_waits,
  output logic [ADDR_W-1:0] HADDR,
  output logic [1:0]        HTRANS,
  output logic              HWRITE,
  output logic [2:0]        HSIZE,
  output logic [2:0]        HBURST,
  output logic [DATA_W-1:0] HWDATA,
  input  logic [DATA_W-1:0] HRDATA,
  input  logic              HREADY,
  input  logic              HRESP
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_ADDR = 2'b01,
    S_DATA = 2'b10,
    S_ERR  = 2'b11
  } state_e;

  state_e            state_q, state_d;
  htrans_e           htrans_q, htrans_d;
  logic [ADDR_W-1:0] haddr_q, haddr_d;
  logic              hwrite_q, hwrite_d;
  logic [DATA_W-1:0] hwdata_q, hwdata_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [WAIT_W-1:0] wait_inc;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_err_q, rsp_err_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic [WAIT_W-1:0] rsp_waits_q, rsp_waits_d;

  // State and output registers; reset abandons any transfer in flight.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q     <= S_IDLE;
      htrans_q    <= HTRANS_IDLE;
      haddr_q     <= '0;
      hwrite_q    <= 1'b0;
      hwdata_q    <= '0;
      wdata_q     <= '0;
      wait_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_waits_q <= '0;
    end else begin
      state_q     <= state_d;
      htrans_q    <= htrans_d;
      haddr_q     <= haddr_d;
      hwrite_q    <= hwrite_d;
      hwdata_q    <= hwdata_d;
      wdata_q     <= wdata_d;
      wait_q      <= wait_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_waits_q <= rsp_waits_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (req_valid) state_d = S_ADDR;
      S_ADDR: if (HREADY) state_d = S_DATA;
      S_DATA: begin
        if (HREADY)    state_d = S_IDLE;
        else if (HRESP) state_d = S_ERR;
      end
      S_ERR:  if (HREADY) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Wait counter sticks at all-ones instead of wrapping.
  assign wait_inc = (wait_q == {WAIT_W{1'b1}}) ? wait_q : wait_q + WAIT_W'(1);

  always_comb begin
    htrans_d    = htrans_q;
    haddr_d     = haddr_q;
    hwrite_d    = hwrite_q;
    hwdata_d    = hwdata_q;
    wdata_d     = wdata_q;
    wait_d      = wait_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_waits_d = rsp_waits_q;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          htrans_d = HTRANS_NONSEQ;
          haddr_d  = req_addr;
          hwrite_d = req_write;
          wdata_d  = req_wdata;
        end
      end
      S_ADDR: begin
        if (HREADY) begin
          htrans_d = HTRANS_IDLE;
          wait_d   = '0;
          if (hwrite_q) hwdata_d = wdata_q;
        end
      end
      S_DATA: begin
        if (HREADY) begin
          rsp_valid_d = 1'b1;
          rsp_waits_d = wait_q;
          rsp_err_d   = (HRESP == HRESP_ERROR);
          rsp_rdata_d = (HRESP == HRESP_OKAY && !hwrite_q) ? HRDATA : '0;
        end else begin
          wait_d = wait_inc;
        end
      end
      S_ERR: begin
        if (HREADY) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
          rsp_waits_d = wait_q;
        end else begin
          wait_d = wait_inc;
        end
      end
      default: ;
    endcase
  end

  assign req_ready = (state_q == S_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_waits = rsp_waits_q;
  assign HADDR     = haddr_q;
  assign HTRANS    = htrans_q;
  assign HWRITE    = hwrite_q;
  assign HSIZE     = HSIZE_VAL;
  assign HBURST    = HBURST_SINGLE;
  assign HWDATA    = hwdata_q;

endmodule

// File: tb/tb_ahb_master_if.sv
// Directed bench for ahb_master_if; the bench acts as the AHB slave cycle by cycle.
module tb_ahb_master_if;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        req_valid, req_write;
  logic [31:0] req_addr, req_wdata;
  logic        req_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic [7:0]  rsp_waits;
  logic [31:0] HADDR, HWDATA, HRDATA;
  logic [1:0]  HTRANS;
  logic        HWRITE, HREADY, HRESP;
  logic [2:0]  HSIZE, HBURST;

  int n_tests = 0;
  int n_fail  = 0;

  ahb_master_if dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_err(rsp_err),
    .rsp_rdata(rsp_rdata), .rsp_waits(rsp_waits),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST),
    .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
  );

  always #5 HCLK = ~HCLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  task automatic request(input logic wr, input logic [31:0] addr, input logic [31:0] wd);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wd;
  endtask

  initial begin
    HRESETn = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    HRDATA = '0; HREADY = 1'b1; HRESP = 1'b0;
    #12;
    check("rst_htrans", 32'(HTRANS), 32'h0);
    check("rst_haddr", HADDR, 32'h0);
    check("rst_hwdata", HWDATA, 32'h0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("rst_hsize", 32'(HSIZE), 32'h2);
    check("rst_hburst", 32'(HBURST), 32'h0);
    @(negedge HCLK);
    HRESETn = 1'b1;
    step();
    check("rst_req_ready", 32'(req_ready), 32'h1);

    // Zero-wait write
    request(1'b1, 32'h40, 32'hDEADBEEF);
    step();
    req_valid = 1'b0;
    check("wr_htrans_nonseq", 32'(HTRANS), 32'h2);
    check("wr_haddr", HADDR, 32'h40);
    check("wr_hwrite", 32'(HWRITE), 32'h1);
    check("wr_req_ready_busy", 32'(req_ready), 32'h0);
    step();
    check("wr_htrans_idle", 32'(HTRANS), 32'h0);
    check("wr_hwdata", HWDATA, 32'hDEADBEEF);
    check("wr_no_rsp_yet", 32'(rsp_valid), 32'h0);
    step();
    check("wr_rsp_valid", 32'(rsp_valid), 32'h1);
    check("wr_rsp_err", 32'(rsp_err), 32'h0);
    check("wr_rsp_waits", 32'(rsp_waits), 32'h0);
    check("wr_rsp_rdata", rsp_rdata, 32'h0);
    check("wr_req_ready", 32'(req_ready), 32'h1);
    step();
    check("wr_rsp_pulse", 32'(rsp_valid), 32'h0);
    check("wr_hwdata_hold", HWDATA, 32'hDEADBEEF);

    // Read with three data-phase wait states
    request(1'b0, 32'h100, 32'h0);
    step();
    req_valid = 1'b0;
    check("rd3_haddr", HADDR, 32'h100);
    check("rd3_hwrite", 32'(HWRITE), 32'h0);
    step();
    HREADY = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("rd3_wait_no_rsp", 32'(rsp_valid), 32'h0);
    end
    HREADY = 1'b1; HRDATA = 32'h12345678;
    step();
    HRDATA = 32'h0;
    check("rd3_rsp_valid", 32'(rsp_valid), 32'h1);
    check("rd3_rdata", rsp_rdata, 32'h12345678);
    check("rd3_waits", 32'(rsp_waits), 32'h3);
    check("rd3_err", 32'(rsp_err), 32'h0);
    check("rd3_hwdata_hold", HWDATA, 32'hDEADBEEF);

    // Read stalled in address phase for two cycles
    request(1'b0, 32'h200, 32'h0);
    HREADY = 1'b0;
    step();
    req_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("as_htrans_stable", 32'(HTRANS), 32'h2);
      check("as_haddr_stable", HADDR, 32'h200);
      if (i == 2) HREADY = 1'b1;
      step();
    end
    check("as_data_htrans", 32'(HTRANS), 32'h0);
    HRDATA = 32'hA5A5A5A5;
    step();
    check("as_rsp_valid", 32'(rsp_valid), 32'h1);
    check("as_rdata", rsp_rdata, 32'hA5A5A5A5);
    check("as_waits", 32'(rsp_waits), 32'h0);
    step();
    check("as_rdata_hold", rsp_rdata, 32'hA5A5A5A5);

    // Write answered with two-cycle ERROR, then back-to-back read
    request(1'b1, 32'h80, 32'h11);
    step();
    req_valid = 1'b0;
    step();
    HRESP = 1'b1; HREADY = 1'b0;
    step();
    check("err_first_no_rsp", 32'(rsp_valid), 32'h0);
    HREADY = 1'b1;
    step();
    HRESP = 1'b0;
    check("err_rsp_valid", 32'(rsp_valid), 32'h1);
    check("err_rsp_err", 32'(rsp_err), 32'h1);
    check("err_rsp_rdata", rsp_rdata, 32'h0);
    check("err_req_ready", 32'(req_ready), 32'h1);
    request(1'b0, 32'h300, 32'h0);
    step();
    req_valid = 1'b0;
    check("b2b_htrans", 32'(HTRANS), 32'h2);
    check("b2b_haddr", HADDR, 32'h300);
    check("b2b_rsp_pulse", 32'(rsp_valid), 32'h0);
    step();
    HRDATA = 32'hCAFEF00D;
    step();
    check("b2b_rsp_valid", 32'(rsp_valid), 32'h1);
    check("b2b_rsp_err", 32'(rsp_err), 32'h0);
    check("b2b_rdata", rsp_rdata, 32'hCAFEF00D);

    // HREADY=1 with HRESP=1 in data phase completes as an error
    request(1'b0, 32'h44, 32'h0);
    step();
    req_valid = 1'b0;
    step();
    HRESP = 1'b1;
    step();
    HRESP = 1'b0;
    check("viol_rsp_valid", 32'(rsp_valid), 32'h1);
    check("viol_rsp_err", 32'(rsp_err), 32'h1);
    check("viol_rdata", rsp_rdata, 32'h0);

    // 300 wait states saturate the counter
    request(1'b0, 32'h500, 32'h0);
    step();
    req_valid = 1'b0;
    step();
    HREADY = 1'b0;
    for (int i = 0; i < 300; i++) step();
    check("sat_no_rsp", 32'(rsp_valid), 32'h0);
    HREADY = 1'b1; HRDATA = 32'h0BADC0DE;
    step();
    check("sat_rsp_valid", 32'(rsp_valid), 32'h1);
    check("sat_waits", 32'(rsp_waits), 32'hFF);
    check("sat_rdata", rsp_rdata, 32'h0BADC0DE);

    // Reset during the data phase of a read
    request(1'b0, 32'h600, 32'h0);
    step();
    req_valid = 1'b0;
    step();
    HREADY = 1'b0;
    step();
    HRESETn = 1'b0;
    #1;
    check("mid_rst_htrans", 32'(HTRANS), 32'h0);
    check("mid_rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("mid_rst_haddr", HADDR, 32'h0);
    check("mid_rst_waits", 32'(rsp_waits), 32'h0);
    HREADY = 1'b1;
    @(negedge HCLK);
    HRESETn = 1'b1;
    step();
    check("mid_rst_req_ready", 32'(req_ready), 32'h1);
    check("mid_rst_no_rsp", 32'(rsp_valid), 32'h0);
    step();
    check("mid_rst_no_rsp2", 32'(rsp_valid), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
